change_dispenser: RTL

- Pays out coins for the candy vending controller: change after a sale, full refund after a cancel.
- On a single-cycle request carrying the controller's result code and the accumulated credit, it computes the amount owed.
- It then drives the coin-ejector mechanism one coin per valid/ack handshake, using the same 2-bit coin encoding the controller accepts on its input, largest denomination first.
- It keeps a per-denomination stock count and flags when exact payout is impossible.

---
 rtl/change_dispenser.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin payout engine for change and refunds with per-denomination stock
module change_dispenser #(
    parameter int PRICE    = 6,
    parameter int AW       = 4,
    parameter int SW       = 4,
    parameter int N25_INIT = 4,
    parameter int N10_INIT = 8,
    parameter int N05_INIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [1:0]    code,
    input  logic [AW-1:0] amount,
    output logic [1:0]    coin,
    output logic          coin_valid,
    input  logic          coin_ack,
    output logic          busy,
    output logic          done,
    output logic          short
);

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

    // Amounts are in 5-cent units; coin codes match the controller's coin input.
    localparam logic [AW-1:0] PRICE_A = AW'(PRICE);
    localparam logic [AW-1:0] V25     = AW'(5);
    localparam logic [AW-1:0] V10     = AW'(2);
    localparam logic [AW-1:0] V05     = AW'(1);
    localparam logic [1:0]    C25     = 2'b11;
    localparam logic [1:0]    C10     = 2'b10;
    localparam logic [1:0]    C05     = 2'b01;

    state_t        state, state_n;
    logic [AW-1:0] remaining, remaining_n;
    logic [1:0]    coin_r, coin_n;
    logic          short_r, short_n;
    logic [SW-1:0] stock25, stock25_n;
    logic [SW-1:0] stock10, stock10_n;
    logic [SW-1:0] stock05, stock05_n;
    logic [AW-1:0] coin_val;

    // Value of the coin currently presented to the ejector.
    always_comb begin
        coin_val = '0;
        case (coin_r)
            C25:     coin_val = V25;
            C10:     coin_val = V10;
            C05:     coin_val = V05;
            default: coin_val = '0;
        endcase
    end

    // State register; reset abandons any payout and reloads the coin stock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            coin_r    <= 2'b00;
            short_r   <= 1'b0;
            stock25   <= SW'(N25_INIT);
            stock10   <= SW'(N10_INIT);
            stock05   <= SW'(N05_INIT);
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            coin_r    <= coin_n;
            short_r   <= short_n;
            stock25   <= stock25_n;
            stock10   <= stock10_n;
            stock05   <= stock05_n;
        end
    end

    // Next-state logic: latch owed amount, pick largest coin in stock, retire on ack.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        coin_n      = coin_r;
        short_n     = short_r;
        stock25_n   = stock25;
        stock10_n   = stock10;
        stock05_n   = stock05;
        case (state)
            IDLE: begin
                if (req) begin
                    short_n = 1'b0;
                    state_n = SELECT;
                    case (code)
                        2'b11:   remaining_n = (amount < PRICE_A) ? '0 : amount - PRICE_A;
                        2'b01:   remaining_n = amount;
                        default: remaining_n = '0;
                    endcase
                end
            end
            SELECT: begin
                if (remaining == '0) begin
                    short_n = 1'b0;
                    state_n = DONE;
                end else if (remaining >= V25 && stock25 != '0) begin
                    coin_n  = C25;
                    state_n = ISSUE;
                end else if (remaining >= V10 && stock10 != '0) begin
                    coin_n  = C10;
                    state_n = ISSUE;
                end else if (remaining >= V05 && stock05 != '0) begin
                    coin_n  = C05;
                    state_n = ISSUE;
                end else begin
                    short_n = 1'b1;
                    state_n = DONE;
                end
            end
            ISSUE: begin
                if (coin_ack) begin
                    remaining_n = (coin_val > remaining) ? '0 : remaining - coin_val;
                    case (coin_r)
                        C25:     if (stock25 != '0) stock25_n = stock25 - 1'b1;
                        C10:     if (stock10 != '0) stock10_n = stock10 - 1'b1;
                        C05:     if (stock05 != '0) stock05_n = stock05 - 1'b1;
                        default: ;
                    endcase
                    coin_n  = 2'b00;
                    state_n = SELECT;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from the registered state so they are glitch-free toward the ejector.
    always_comb begin
        coin_valid = (state == ISSUE);
        coin       = (state == ISSUE) ? coin_r : 2'b00;
        busy       = (state != IDLE);
        done       = (state == DONE);
        short      = (state == DONE) && short_r;
    end

endmodule
